// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage. Passes ALU results to writeback and
// runs load/store requests to the data cache with a req/ready handshake.
// Optional build macro: MEMORY_STAGE_PERF_EN adds load/store/stall counters.
module memory_access_stage #(
   parameter int WORD_WIDTH           = 32,
   parameter int REGISTER_INDEX_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic                            cu_mem_to_reg_in,
   input  logic                            cu_mem_write_in,
   input  logic                            cu_byte_in,
   input  logic                            cu_reg_write_in,
   input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
   input  logic [WORD_WIDTH-1:0]           alu_result_in,
   input  logic [WORD_WIDTH-1:0]           store_data_in,
   output logic                            stall_out,
   output logic                            mem_req,
   output logic                            mem_we,
   output logic                            mem_byte,
   output logic [WORD_WIDTH-1:0]           mem_addr,
   output logic [WORD_WIDTH-1:0]           mem_wdata,
   input  logic [WORD_WIDTH-1:0]           mem_rdata,
   input  logic                            mem_ready,
`ifdef MEMORY_STAGE_PERF_EN
   output logic [31:0]                     perf_loads,
   output logic [31:0]                     perf_stores,
   output logic [31:0]                     perf_stall_cycles,
`endif
   output logic                            wb_valid,
   output logic                            wb_reg_write,
   output logic [REGISTER_INDEX_WIDTH-1:0] wb_destination_register,
   output logic [WORD_WIDTH-1:0]           wb_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t                          state_q, state_d;
   logic                            mem_req_q, mem_req_d;
   logic                            mem_we_q, mem_we_d;
   logic                            mem_byte_q, mem_byte_d;
   logic [WORD_WIDTH-1:0]           mem_addr_q, mem_addr_d;
   logic [WORD_WIDTH-1:0]           mem_wdata_q, mem_wdata_d;
   logic                            is_load_q, is_load_d;
   logic                            rw_q, rw_d;
   logic [REGISTER_INDEX_WIDTH-1:0] dest_q, dest_d;
   logic                            wb_valid_q, wb_valid_d;
   logic                            wb_rw_q, wb_rw_d;
   logic [REGISTER_INDEX_WIDTH-1:0] wb_dest_q, wb_dest_d;
   logic [WORD_WIDTH-1:0]           wb_data_q, wb_data_d;

   logic                            accept;
   logic [7:0]                      load_byte;

   // Upstream is held only while a cache access is outstanding.
   assign stall_out = (state_q == ACCESS);
   assign accept    = in_valid && !stall_out;

   // Little-endian lane pick for byte loads.
   assign load_byte = mem_rdata[8*mem_addr_q[1:0] +: 8];

   // Next-state and output-register computation.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_byte_d  = mem_byte_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      is_load_d   = is_load_q;
      rw_d        = rw_q;
      dest_d      = dest_q;
      wb_valid_d  = 1'b0;
      wb_rw_d     = wb_rw_q;
      wb_dest_d   = wb_dest_q;
      wb_data_d   = wb_data_q;
      unique case (state_q)
         ACCESS: begin
            if (mem_ready) begin
               state_d    = RESPOND;
               mem_req_d  = 1'b0;
               wb_valid_d = 1'b1;
               wb_dest_d  = dest_q;
               if (is_load_q) begin
                  wb_rw_d   = rw_q && (dest_q != '0);
                  wb_data_d = mem_byte_q ? {{(WORD_WIDTH-8){1'b0}}, load_byte} : mem_rdata;
               end else begin
                  wb_rw_d   = 1'b0;
                  wb_data_d = mem_addr_q;
               end
            end
         end
         default: begin
            // IDLE and RESPOND share the accept rules.
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (accept) begin
               if (cu_mem_to_reg_in || cu_mem_write_in) begin
                  state_d     = ACCESS;
                  mem_req_d   = 1'b1;
                  // A load flag wins when both flags are set.
                  mem_we_d    = cu_mem_write_in && !cu_mem_to_reg_in;
                  mem_byte_d  = cu_byte_in;
                  mem_addr_d  = alu_result_in;
                  mem_wdata_d = cu_byte_in ? {(WORD_WIDTH/8){store_data_in[7:0]}} : store_data_in;
                  is_load_d   = cu_mem_to_reg_in;
                  rw_d        = cu_reg_write_in;
                  dest_d      = destination_register_in;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_rw_d    = cu_reg_write_in && (destination_register_in != '0);
                  wb_dest_d  = destination_register_in;
                  wb_data_d  = alu_result_in;
               end
            end
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_byte_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         is_load_q   <= 1'b0;
         rw_q        <= 1'b0;
         dest_q      <= '0;
         wb_valid_q  <= 1'b0;
         wb_rw_q     <= 1'b0;
         wb_dest_q   <= '0;
         wb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_byte_q  <= mem_byte_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         is_load_q   <= is_load_d;
         rw_q        <= rw_d;
         dest_q      <= dest_d;
         wb_valid_q  <= wb_valid_d;
         wb_rw_q     <= wb_rw_d;
         wb_dest_q   <= wb_dest_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign mem_req                 = mem_req_q;
   assign mem_we                  = mem_we_q;
   assign mem_byte                = mem_byte_q;
   assign mem_addr                = mem_addr_q;
   assign mem_wdata               = mem_wdata_q;
   assign wb_valid                = wb_valid_q;
   assign wb_reg_write            = wb_rw_q;
   assign wb_destination_register = wb_dest_q;
   assign wb_data                 = wb_data_q;

`ifdef MEMORY_STAGE_PERF_EN
   logic [31:0] perf_loads_q, perf_stores_q, perf_stall_q;
   logic        done_access;

   assign done_access = (state_q == ACCESS) && mem_ready;

   // Completed-access and stall-cycle counters; wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_loads_q  <= '0;
         perf_stores_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (done_access && is_load_q)  perf_loads_q  <= perf_loads_q + 32'd1;
         if (done_access && !is_load_q) perf_stores_q <= perf_stores_q + 32'd1;
         if (stall_out)                 perf_stall_q  <= perf_stall_q + 32'd1;
      end
   end

   assign perf_loads        = perf_loads_q;
   assign perf_stores       = perf_stores_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage.
module tb_memory_access_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, ld, st, byt, rw;
   logic [4:0]  dest;
   logic [31:0] alu, sdata;
   logic        stall_out, mem_req, mem_we, mem_byte;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
`ifdef MEMORY_STAGE_PERF_EN
   logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   memory_access_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .cu_mem_to_reg_in(ld), .cu_mem_write_in(st), .cu_byte_in(byt),
      .cu_reg_write_in(rw), .destination_register_in(dest),
      .alu_result_in(alu), .store_data_in(sdata),
      .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
      .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef MEMORY_STAGE_PERF_EN
      .perf_loads(perf_loads), .perf_stores(perf_stores),
      .perf_stall_cycles(perf_stall_cycles),
`endif
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_destination_register(wb_dest), .wb_data(wb_data)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; ld = 0; st = 0; byt = 0; rw = 0; dest = 0;
      alu = 0; sdata = 0; mem_ready = 0; mem_rdata = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick(); tick();
      total++;
      if ({wb_valid, mem_req, stall_out, mem_we, mem_byte, wb_reg_write} !== 6'b0)
         $display("FAIL reset_ctrl got %b want 000000", {wb_valid, mem_req, stall_out, mem_we, mem_byte, wb_reg_write});
      else passed++;
      total++;
      if ({mem_addr, mem_wdata, wb_data, wb_dest} !== 101'd0)
         $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wdata, wb_data, wb_dest);
      else passed++;
      rst = 0;
   endtask

   task automatic test_alu_pass();
      in_valid = 1; alu = 32'h0000_1234; dest = 5; rw = 1;
      tick();
      idle_inputs();
      total++;
      if ({wb_valid, wb_reg_write, stall_out} !== 3'b110 || wb_data !== 32'h1234 || wb_dest !== 5'd5)
         $display("FAIL alu_pass got v=%b rw=%b st=%b d=%h r=%0d want 1 1 0 1234 5", wb_valid, wb_reg_write, stall_out, wb_data, wb_dest);
      else passed++;
      tick();
      total++;
      if (wb_valid !== 1'b0 || wb_data !== 32'h1234)
         $display("FAIL alu_pulse got v=%b d=%h want 0 1234", wb_valid, wb_data);
      else passed++;
   endtask

   task automatic test_word_load();
      int req_cycles = 0;
      int stall_cycles = 0;
      in_valid = 1; ld = 1; alu = 32'h100; dest = 7; rw = 1;
      tick();
      idle_inputs();
      total++;
      if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_byte !== 1'b0)
         $display("FAIL wload_req got a=%h we=%b b=%b want 100 0 0", mem_addr, mem_we, mem_byte);
      else passed++;
      for (int c = 0; c < 3; c++) begin
         if (mem_req) req_cycles++;
         if (stall_out) stall_cycles++;
         // An ALU packet offered while stalled must be ignored.
         in_valid = (c == 1); alu = 32'h999; dest = 9; rw = 1;
         mem_ready = (c == 2); mem_rdata = 32'hDEADBEEF;
         tick();
      end
      idle_inputs();
      total++;
      if (req_cycles != 3 || stall_cycles != 3)
         $display("FAIL wload_len got req=%0d stall=%0d want 3 3", req_cycles, stall_cycles);
      else passed++;
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_dest !== 5'd7 || wb_reg_write !== 1'b1)
         $display("FAIL wload_wb got v=%b d=%h r=%0d rw=%b want 1 deadbeef 7 1", wb_valid, wb_data, wb_dest, wb_reg_write);
      else passed++;
      total++;
      if (mem_req !== 1'b0 || stall_out !== 1'b0)
         $display("FAIL wload_drop got req=%b st=%b want 0 0", mem_req, stall_out);
      else passed++;
      tick();
      total++;
      if (wb_valid !== 1'b0)
         $display("FAIL wload_ignore got v=%b want 0", wb_valid);
      else passed++;
   endtask

   task automatic test_byte_load();
      in_valid = 1; ld = 1; byt = 1; alu = 32'h103; dest = 4; rw = 1;
      tick();
      idle_inputs();
      mem_ready = 1; mem_rdata = 32'hAABBCCDD;
      tick();
      idle_inputs();
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00AA)
         $display("FAIL bload got v=%b d=%h want 1 000000aa", wb_valid, wb_data);
      else passed++;
      tick();
   endtask

   task automatic test_byte_store();
      in_valid = 1; st = 1; byt = 1; alu = 32'h201; sdata = 32'h12345678; dest = 3; rw = 1;
      tick();
      idle_inputs();
      total++;
      if ({mem_req, mem_we, mem_byte} !== 3'b111 || mem_wdata !== 32'h78787878 || mem_addr !== 32'h201)
         $display("FAIL bstore_req got rwb=%b%b%b wd=%h a=%h want 111 78787878 201", mem_req, mem_we, mem_byte, mem_wdata, mem_addr);
      else passed++;
      mem_ready = 1;
      tick();
      idle_inputs();
      total++;
      if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h201)
         $display("FAIL bstore_wb got v=%b rw=%b d=%h want 1 0 201", wb_valid, wb_reg_write, wb_data);
      else passed++;
      tick();
   endtask

   task automatic test_reg0();
      in_valid = 1; alu = 32'hCAFE; dest = 0; rw = 1;
      tick();
      idle_inputs();
      total++;
      if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
         $display("FAIL reg0 got v=%b rw=%b want 1 0", wb_valid, wb_reg_write);
      else passed++;
      tick();
   endtask

   task automatic test_load_store_both();
      in_valid = 1; ld = 1; st = 1; alu = 32'h40; sdata = 32'h11223344; dest = 6; rw = 1;
      tick();
      idle_inputs();
      total++;
      if (mem_we !== 1'b0 || mem_wdata !== 32'h11223344)
         $display("FAIL both_flags got we=%b wd=%h want 0 11223344", mem_we, mem_wdata);
      else passed++;
      mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
      tick();
      idle_inputs();
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h5A5A5A5A || wb_reg_write !== 1'b1)
         $display("FAIL both_wb got v=%b d=%h rw=%b want 1 5a5a5a5a 1", wb_valid, wb_data, wb_reg_write);
      else passed++;
      tick();
   endtask

   task automatic test_back_to_back();
      in_valid = 1; ld = 1; alu = 32'h10; dest = 1; rw = 1;
      tick();
      idle_inputs();
      mem_ready = 1; mem_rdata = 32'h0BADF00D;
      tick();
      // RESPOND cycle: offer an ALU packet, which must be accepted here.
      idle_inputs();
      in_valid = 1; alu = 32'h777; dest = 2; rw = 1;
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h0BADF00D || stall_out !== 1'b0)
         $display("FAIL b2b_load got v=%b d=%h st=%b want 1 0badf00d 0", wb_valid, wb_data, stall_out);
      else passed++;
      tick();
      idle_inputs();
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h777 || wb_dest !== 5'd2)
         $display("FAIL b2b_alu got v=%b d=%h r=%0d want 1 777 2", wb_valid, wb_data, wb_dest);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      in_valid = 1; ld = 1; alu = 32'h300; dest = 8; rw = 1;
      tick();
      idle_inputs();
      total++;
      if (mem_req !== 1'b1)
         $display("FAIL midrst_req got %b want 1", mem_req);
      else passed++;
      rst = 1;
      tick();
      total++;
      if (mem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0)
         $display("FAIL midrst_abandon got req=%b st=%b v=%b want 0 0 0", mem_req, stall_out, wb_valid);
      else passed++;
      rst = 0;
      // Late ready arrives in IDLE alongside a fresh ALU packet.
      mem_ready = 1; mem_rdata = 32'hFFFF0000;
      in_valid = 1; alu = 32'h55; dest = 2; rw = 1;
      tick();
      idle_inputs();
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h55 || mem_req !== 1'b0)
         $display("FAIL midrst_new got v=%b d=%h req=%b want 1 55 0", wb_valid, wb_data, mem_req);
      else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_alu_pass();
      test_word_load();
      test_byte_load();
      test_byte_store();
      test_reg0();
      test_load_store_both();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
